// File: rtl/bf_pkg.sv
// Shared definitions for the beamformer blocks.
// Holds the state encodings used on debug_state (IDLE/ARM/FIRE/DONE), the
// default channel count and delay width, and a helper that sizes
// channel-index buses.
package bf_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_FIRE = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int N_CH_DEF    = 4;
    localparam int DELAY_W_DEF = 8;

    // Width of a channel index; never less than one bit.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tx_beamformer_if.sv
// Host/pulser bundle for tx_beamformer.
// master: host side. It drives start, cfg_we, cfg_addr and cfg_data, and it
//         observes tx_p, tx_n, busy, rx_start and debug_state.
// slave:  beamformer side, with the opposite directions.
// The per-channel bit vectors are tx_p and tx_n. The channel index on
// cfg_addr is addr_w(N_CH) bits wide.
interface tx_beamformer_if
    import bf_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int DELAY_W = DELAY_W_DEF
);
    localparam int AW = addr_w(N_CH);

    logic                start;
    logic                cfg_we;
    logic [AW-1:0]       cfg_addr;
    logic [DELAY_W-1:0]  cfg_data;
    logic [N_CH-1:0]     tx_p;
    logic [N_CH-1:0]     tx_n;
    logic                busy;
    logic                rx_start;
    logic [1:0]          debug_state;

    modport master (
        output start, cfg_we, cfg_addr, cfg_data,
        input  tx_p, tx_n, busy, rx_start, debug_state
    );

    modport slave (
        input  start, cfg_we, cfg_addr, cfg_data,
        output tx_p, tx_n, busy, rx_start, debug_state
    );

endinterface

// File: rtl/tx_beamformer_pulse_gen.sv
// tx_pulse_gen: generates the bipolar burst for one transducer channel.
// Ports:
//   clk, reset : system clock and asynchronous active-high reset.
//   fire_en    : high while the shot is in FIRE.
//   t          : shot counter, DELAY_W+1 bits.
//   delay      : this channel's focal-law delay.
//   p, n       : registered positive/negative phase drive.
// The channel is active for N_HALF*HALF_PERIOD cycles, starting at t == delay.
// A half-period sub-counter and a phase bit step through the half-cycles, so no
// divider is needed to find the half-cycle index.
module tx_pulse_gen #(
    parameter int DELAY_W     = 8,
    parameter int HALF_PERIOD = 2,
    parameter int N_HALF      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fire_en,
    input  logic [DELAY_W:0]   t,
    input  logic [DELAY_W-1:0] delay,
    output logic               p,
    output logic               n
);
    localparam int TW    = DELAY_W + 1;
    localparam int BURST = N_HALF * HALF_PERIOD;
    localparam int CW    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

    logic [TW-1:0] start_t;
    logic [TW-1:0] end_t;
    logic          active;

    logic [CW-1:0] hp_cnt_q, hp_cnt_d;
    logic          phase_q,  phase_d;
    logic          p_q,      p_d;
    logic          n_q,      n_d;

    // end_t fits in TW bits because BURST <= 2^DELAY_W.
    assign start_t = TW'(delay);
    assign end_t   = TW'(delay) + TW'(BURST);
    assign active  = fire_en && (t >= start_t) && (t < end_t);

    always_comb begin
        // NOTE: every variable gets a value before any branch, so that no path leaves it unassigned and infers a latch.
        hp_cnt_d = hp_cnt_q;
        phase_d  = phase_q;
        p_d      = 1'b0;
        n_d      = 1'b0;
        if (active) begin
            // phase 0 means an even half-index (positive drive).
            p_d = ~phase_q;
            n_d = phase_q;
            if (hp_cnt_q == CW'(HALF_PERIOD - 1)) begin
                hp_cnt_d = '0;
                phase_d  = ~phase_q;
            end else begin
                hp_cnt_d = hp_cnt_q + CW'(1);
            end
        end else begin
            // Re-arm so that the next window starts on a positive half.
            hp_cnt_d = '0;
            phase_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state uses non-blocking assignments so that every flop samples its pre-edge inputs, whatever order the blocks evaluate in.
        if (reset) begin
            hp_cnt_q <= '0;
            phase_q  <= 1'b0;
            p_q      <= 1'b0;
            n_q      <= 1'b0;
        end else begin
            hp_cnt_q <= hp_cnt_d;
            phase_q  <= phase_d;
            p_q      <= p_d;
            n_q      <= n_d;
        end
    end

    assign p = p_q;
    assign n = n_q;

endmodule

// File: rtl/tx_beamformer.sv
// tx_beamformer: transmit focal-law sequencer.
// Ports:
//   clk   : system clock.
//   reset : asynchronous active-high reset.
//   bus   : tx_beamformer_if.slave. It carries the start request, the delay
//           table write port, the per-channel pulser drives, busy, rx_start
//           and debug_state.
// Sequence:
//   IDLE : accepts a rising edge of start.
//   ARM  : scans the table for the largest delay, one entry per cycle.
//   FIRE : runs the shot counter. Each channel bursts in its own window.
//   DONE : one cycle.
// After DONE the block pulses rx_start, which launches the receive side.
module tx_beamformer
    import bf_pkg::*;
#(
    parameter int N_CH        = N_CH_DEF,
    parameter int DELAY_W     = DELAY_W_DEF,
    parameter int HALF_PERIOD = 2,
    parameter int N_HALF      = 4
) (
    input  logic         clk,
    input  logic         reset,
    tx_beamformer_if.slave bus
);
    localparam int AW    = addr_w(N_CH);
    localparam int TW    = DELAY_W + 1;
    localparam int BURST = N_HALF * HALF_PERIOD;

    logic [1:0]         state_q,     state_d;
    logic               start_q;
    logic [DELAY_W-1:0] delay_q [N_CH];
    logic [DELAY_W-1:0] delay_d [N_CH];
    logic [DELAY_W-1:0] max_delay_q, max_delay_d;
    logic [AW-1:0]      k_q,         k_d;
    logic [TW-1:0]      t_q,         t_d;
    logic               rx_start_q,  rx_start_d;

    logic               start_accept;
    logic               fire_en;
    logic [N_CH-1:0]    tx_p_w;
    logic [N_CH-1:0]    tx_n_w;

    assign start_accept = (state_q == ST_IDLE) && bus.start && !start_q;
    assign fire_en      = (state_q == ST_FIRE);

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        max_delay_d = max_delay_q;
        k_d         = k_q;
        t_d         = t_q;
        rx_start_d  = 1'b0;

        // The table is writable only in IDLE. A write in the same cycle as an
        // accepted start lands before ARM reads it, so that shot uses it.
        if (state_q == ST_IDLE && bus.cfg_we) begin
            delay_d[bus.cfg_addr] = bus.cfg_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    state_d     = ST_ARM;
                    k_d         = '0;
                    max_delay_d = '0;
                end
            end
            ST_ARM: begin
                if (delay_q[k_q] > max_delay_q) begin
                    max_delay_d = delay_q[k_q];
                end
                if (k_q == AW'(N_CH - 1)) begin
                    state_d = ST_FIRE;
                    t_d     = '0;
                end else begin
                    k_d = k_q + AW'(1);
                end
            end
            ST_FIRE: begin
                // The last FIRE cycle is the final active cycle of the
                // latest-starting channel.
                if (t_q == TW'(max_delay_q) + TW'(BURST - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    t_d = t_q + TW'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                rx_start_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            max_delay_q <= '0;
            k_q         <= '0;
            t_q         <= '0;
            rx_start_q  <= 1'b0;
            // NOTE: the delay table is reset on purpose. A shot fired before the host programs the table must see all-zero delays.
            for (int i = 0; i < N_CH; i++) begin
                delay_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            start_q     <= bus.start;
            max_delay_q <= max_delay_d;
            k_q         <= k_d;
            t_q         <= t_d;
            rx_start_q  <= rx_start_d;
            delay_q     <= delay_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        tx_pulse_gen #(
            .DELAY_W     (DELAY_W),
            .HALF_PERIOD (HALF_PERIOD),
            .N_HALF      (N_HALF)
        ) u_pulse (
            .clk     (clk),
            .reset   (reset),
            .fire_en (fire_en),
            .t       (t_q),
            .delay   (delay_q[i]),
            .p       (tx_p_w[i]),
            .n       (tx_n_w[i])
        );
    end

    assign bus.tx_p        = tx_p_w;
    assign bus.tx_n        = tx_n_w;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.rx_start    = rx_start_q;
    assign bus.debug_state = state_q;

endmodule

// File: tb/tb_tx_beamformer.sv
// Testbench for tx_beamformer.
// A model of the shot timeline fills a queue with the expected cycle-by-cycle
// outputs when each shot is launched. A negedge monitor pops an entry and
// compares it in every cycle. The monitor also checks that the two phases
// never overlap and counts the active cycles of each burst.
module tb_tx_beamformer;
    import bf_pkg::*;

    localparam int N_CH    = 4;
    localparam int DELAY_W = 8;
    localparam int HP      = 2;
    localparam int NH      = 4;
    localparam int BURST   = NH * HP;
    localparam int AW      = addr_w(N_CH);

    typedef struct packed {
        logic [1:0]      st;
        logic            busy;
        logic            rx;
        logic [N_CH-1:0] p;
        logic [N_CH-1:0] n;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tx_beamformer_if #(.N_CH(N_CH), .DELAY_W(DELAY_W)) bus ();

    tx_beamformer #(
        .N_CH        (N_CH),
        .DELAY_W     (DELAY_W),
        .HALF_PERIOD (HP),
        .N_HALF      (NH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t sb_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   model_delay[N_CH];
    int   act_cnt[N_CH];
    exp_t mon_e;
    exp_t mon_o;

    // Monitor: runs every cycle, away from the rising edge.
    always @(negedge clk) begin
        mon_o = {bus.debug_state, bus.busy, bus.rx_start, bus.tx_p, bus.tx_n};
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            tests_run++;
            if (mon_o !== mon_e) begin
                tests_failed++;
                $display("FAIL shot_cycle @%0t: got st=%0d busy=%b rx=%b p=%b n=%b, expected st=%0d busy=%b rx=%b p=%b n=%b",
                         $time, mon_o.st, mon_o.busy, mon_o.rx, mon_o.p, mon_o.n,
                         mon_e.st, mon_e.busy, mon_e.rx, mon_e.p, mon_e.n);
            end
        end
        tests_run++;
        if ((bus.tx_p & bus.tx_n) !== '0) begin
            tests_failed++;
            $display("FAIL exclusive @%0t: tx_p=%b tx_n=%b, expected no common bit", $time, bus.tx_p, bus.tx_n);
        end
        if (reset) begin
            for (int i = 0; i < N_CH; i++) act_cnt[i] = 0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.tx_p[i] | bus.tx_n[i]) act_cnt[i]++;
            end
            if (bus.rx_start === 1'b1) begin
                for (int i = 0; i < N_CH; i++) begin
                    tests_run++;
                    if (act_cnt[i] != BURST) begin
                        tests_failed++;
                        $display("FAIL burst_len ch%0d: got %0d active cycles, expected %0d", i, act_cnt[i], BURST);
                    end
                    act_cnt[i] = 0;
                end
            end
        end
    end

    // Expected timeline, counted from the accepting edge. Cycle c=1 is the
    // first ARM cycle and F = N_CH+1 is the first FIRE cycle. Channel i drives
    // at cycles F+1+delay .. F+delay+BURST.
    function automatic void push_shot();
        int   m;
        int   f;
        int   last;
        int   off;
        exp_t e;
        m = 0;
        for (int i = 0; i < N_CH; i++) if (model_delay[i] > m) m = model_delay[i];
        f    = N_CH + 1;
        last = N_CH + m + BURST + 2;
        for (int c = 1; c <= last; c++) begin
            e = '0;
            if (c <= N_CH)                     e.st = ST_ARM;
            else if (c <= N_CH + m + BURST)    e.st = ST_FIRE;
            else if (c == N_CH + m + BURST + 1) e.st = ST_DONE;
            else                               e.st = ST_IDLE;
            e.busy = (c <= N_CH + m + BURST + 1);
            e.rx   = (c == last);
            for (int i = 0; i < N_CH; i++) begin
                off = c - f - 1 - model_delay[i];
                if (off >= 0 && off < BURST) begin
                    e.p[i] = ((off / HP) % 2 == 0);
                    e.n[i] = ((off / HP) % 2 == 1);
                end
            end
            sb_q.push_back(e);
        end
    endfunction

    function automatic int shot_len();
        int m;
        m = 0;
        for (int i = 0; i < N_CH; i++) if (model_delay[i] > m) m = model_delay[i];
        return N_CH + m + BURST + 2;
    endfunction

    task automatic cfg_write(input int ch, input int val, input bit update_model);
        @(posedge clk); #1;
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = AW'(ch);
        bus.cfg_data = DELAY_W'(val);
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        if (update_model) model_delay[ch] = val;
    endtask

    task automatic load_law(input int d0, input int d1, input int d2, input int d3);
        cfg_write(0, d0, 1'b1);
        cfg_write(1, d1, 1'b1);
        cfg_write(2, d2, 1'b1);
        cfg_write(3, d3, 1'b1);
    endtask

    // Raises start. The expected timeline is queued at the accepting edge.
    task automatic launch_shot(input bit push, input bit hold, input bit wr,
                               input int wr_ch, input int wr_val);
        @(posedge clk); #1;
        bus.start = 1'b1;
        if (wr) begin
            bus.cfg_we   = 1'b1;
            bus.cfg_addr = AW'(wr_ch);
            bus.cfg_data = DELAY_W'(wr_val);
            model_delay[wr_ch] = wr_val;
        end
        @(posedge clk);
        if (push) push_shot();
        #1;
        if (!hold) bus.start = 1'b0;
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 4000 && sb_q.size() != 0; i++) @(negedge clk);
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL %s_timeout: %0d expected cycles left, expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
        for (int i = 0; i < N_CH; i++) begin model_delay[i] = 0; act_cnt[i] = 0; end
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({bus.debug_state, bus.busy, bus.rx_start, bus.tx_p, bus.tx_n} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: got st=%0d busy=%b rx=%b p=%b n=%b, expected all 0",
                     bus.debug_state, bus.busy, bus.rx_start, bus.tx_p, bus.tx_n);
        end
        reset = 1'b0;
    endtask

    task automatic test_staggered();
        load_law(0, 3, 1, 2);
        launch_shot(1'b1, 1'b0, 1'b0, 0, 0);
        wait_drain("staggered");
    endtask

    task automatic test_zero_delays();
        load_law(0, 0, 0, 0);
        launch_shot(1'b1, 1'b0, 1'b0, 0, 0);
        wait_drain("zero_delays");
    endtask

    task automatic test_reset_mid_fire();
        load_law(0, 3, 1, 2);
        launch_shot(1'b0, 1'b0, 1'b0, 0, 0);
        // Cycle 8 from acceptance: ch0 negative, ch2 and ch3 positive, ch1 quiet.
        repeat (7) @(posedge clk);
        #3;
        tests_run++;
        if (bus.tx_p !== 4'b1100 || bus.tx_n !== 4'b0001 || bus.debug_state !== ST_FIRE) begin
            tests_failed++;
            $display("FAIL mid_fire_pre: got st=%0d p=%b n=%b, expected st=2 p=1100 n=0001",
                     bus.debug_state, bus.tx_p, bus.tx_n);
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.debug_state, bus.busy, bus.rx_start, bus.tx_p, bus.tx_n} !== '0) begin
            tests_failed++;
            $display("FAIL mid_fire_reset: got st=%0d busy=%b rx=%b p=%b n=%b, expected all 0",
                     bus.debug_state, bus.busy, bus.rx_start, bus.tx_p, bus.tx_n);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        // The table was cleared, so the next shot runs with all-zero delays.
        for (int i = 0; i < N_CH; i++) model_delay[i] = 0;
        launch_shot(1'b1, 1'b0, 1'b0, 0, 0);
        wait_drain("after_reset");
    endtask

    task automatic test_level_start();
        exp_t idle_e;
        int   extra;
        load_law(2, 0, 1, 3);
        extra = 2 * shot_len();
        launch_shot(1'b1, 1'b1, 1'b0, 0, 0);
        idle_e = '0;
        for (int i = 0; i < extra; i++) sb_q.push_back(idle_e);
        wait_drain("level_hold");
        @(posedge clk); #1;
        bus.start = 1'b0;
        launch_shot(1'b1, 1'b0, 1'b0, 0, 0);
        wait_drain("level_second");
    endtask

    task automatic test_cfg_lockout();
        load_law(1, 2, 3, 4);
        launch_shot(1'b1, 1'b0, 1'b0, 0, 0);
        repeat (5) @(posedge clk);
        #1;
        bus.cfg_we = 1'b1; bus.cfg_addr = AW'(1); bus.cfg_data = DELAY_W'(7);
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        wait_drain("lockout_fire");
        launch_shot(1'b1, 1'b0, 1'b0, 0, 0);
        wait_drain("lockout_old");
        cfg_write(1, 7, 1'b1);
        launch_shot(1'b1, 1'b0, 1'b0, 0, 0);
        wait_drain("lockout_idle");
    endtask

    task automatic test_same_cycle_write();
        load_law(0, 1, 2, 0);
        launch_shot(1'b1, 1'b0, 1'b1, 3, 5);
        wait_drain("same_cycle_write");
    endtask

    task automatic test_max_delay();
        load_law(255, 0, 128, 7);
        launch_shot(1'b1, 1'b0, 1'b0, 0, 0);
        wait_drain("max_delay");
    endtask

    task automatic test_random_shots();
        for (int s = 0; s < 200; s++) begin
            load_law($urandom_range(0, 63), $urandom_range(0, 63),
                     $urandom_range(0, 63), $urandom_range(0, 63));
            launch_shot(1'b1, 1'b0, 1'b0, 0, 0);
            wait_drain("random");
        end
    endtask

    initial begin
        test_reset();
        test_staggered();
        test_zero_delays();
        test_reset_mid_fire();
        test_level_start();
        test_cfg_lockout();
        test_same_cycle_write();
        test_max_delay();
        test_random_shots();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/tx_beamformer.md
Name: tx_beamformer

Overview:
- Transmit-side counterpart of the receive beamformer top_bf.
- Holds a per-channel focal-law delay table written by the host, and fires one bipolar burst per transducer channel on start, each channel offset by its programmed delay.
- After the last channel finishes, it pulses rx_start to launch the receive beamformer for the same shot.
- Sits between the host/config bus and the pulser drivers; rx_start connects to top_bf start.

Parameters:
- N_CH, 4, number of transducer channels.
- DELAY_W, 8, width of each per-channel delay (clock cycles).
- HALF_PERIOD, 2, clock cycles per pulse half-cycle; must be at least 1.
- N_HALF, 4, half-cycles per burst. Constraint: N_HALF*HALF_PERIOD <= 2^DELAY_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  shot request; rising edge accepted only in IDLE.
- cfg_we  input  1  delay table write strobe.
- cfg_addr  input  clog2(N_CH)  channel index for the write.
- cfg_data  input  DELAY_W  delay value for the write.
- tx_p  output  N_CH  positive-phase drive, one bit per channel.
- tx_n  output  N_CH  negative-phase drive, one bit per channel.
- busy  output  1  high in every state except IDLE.
- rx_start  output  1  one-cycle pulse when the shot completes.
- debug_state  output  2  current state encoding.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; tx_p=0, tx_n=0, busy=0, rx_start=0, debug_state=0.
  - All delay entries=0; max_delay=0; counters=0; start_q=0.
- Reset asserted mid-shot aborts the shot at once; all drive outputs go low with no glitch pulse.
- Start detection: start_q is a register of start. A shot is accepted when state==IDLE, start==1 and start_q==0. Holding start high does not re-fire.
- Config writes:
  - Honoured only in IDLE: delay[cfg_addr] <= cfg_data.
  - Ignored in all other states.
  - A write in the same cycle as an accepted start is committed, and the new value is used for that shot.
- States (debug_state encoding):
  - IDLE=0: wait for an accepted start, then go to ARM.
  - ARM=1: lasts exactly N_CH cycles. Channel index k scans 0..N_CH-1 and forms max_delay = max(delay[k]). After the last index, go to FIRE with t=0.
  - FIRE=2:
    - Shot counter t (width DELAY_W+1) increments each cycle.
    - Channel i is active when delay[i] <= t < delay[i] + N_HALF*HALF_PERIOD.
    - Half-index h = (t - delay[i]) / HALF_PERIOD, implemented with per-channel sub-counters, no divider.
    - Drive rule: tx_p[i]=1 when active and h even; tx_n[i]=1 when active and h odd.
    - Leave FIRE after the cycle with t == max_delay + N_HALF*HALF_PERIOD - 1.
  - DONE=3: lasts one cycle. rx_start=1 is registered so it is seen high in the cycle after DONE. Then return to IDLE.
- Output timing: tx_p/tx_n are registered, so they lag the t comparison by one cycle. Channel i first goes high at cycle F+1+delay[i], where F is the first FIRE cycle.
- Invariants:
  - tx_p[i] & tx_n[i] is never 1.
  - Outputs are 0 outside the active window.
- Boundary: if all delays are 0, every channel fires in parallel and FIRE lasts N_HALF*HALF_PERIOD cycles.
- Total shot time: N_CH + max_delay + N_HALF*HALF_PERIOD + 1 cycles from acceptance to DONE.

Decomposition:
- Shared package bf_pkg holds:
  - state encodings (IDLE/ARM/FIRE/DONE, shared with the debug_state convention of top_bf);
  - default N_CH and DELAY_W.
- One sub-module, tx_pulse_gen, instantiated N_CH times.
  - Inputs: clk, reset, fire_en, t, delay, and the parameters.
  - Contains the half-period sub-counter and the phase toggle.
  - Outputs: registered p/n for its channel.
- The top level owns the FSM, the delay table, the max-delay scan and rx_start.

Test Plan:
- Reset check: assert reset mid-FIRE -> tx_p=tx_n=0 at once, debug_state=0, busy=0; after release, a new start runs a full shot.
- Staggered law: delays {0,3,1,2}, defaults, start rises -> ARM 4 cycles.
  - ch0 pattern p,p,n,n,p,p,n,n begins at F+1; ch2 at F+2; ch3 at F+3; ch1 at F+4.
  - FIRE lasts 11 cycles; rx_start is high exactly once.
- Zero delays: all delays 0 -> all 4 channels have identical waveforms; FIRE lasts 8 cycles.
- Level start: start held high across two shot durations -> only one shot; drop start and raise it again -> second shot fires.
- Config lockout: cfg_we to ch1 with value 7 during FIRE -> ignored; the next shot uses the old value. Same write in IDLE -> next shot's ch1 burst begins at F+8.
- Exclusivity: random delays over 200 shots -> tx_p&tx_n is never set; each burst has exactly N_HALF*HALF_PERIOD active cycles per channel.
